// File: rtl/alu_control_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_control_pkg : opcode, func and ALU function-code constants           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_control_pkg;

  // Primary opcodes, instruction [31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes, instruction [5:0]
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

endpackage

`default_nettype wire

// File: rtl/alu_control_dmem_alu32.sv
// +--------------------------------------------------------------------------+
// | alu32 : 32-bit wrap-around ALU with zero flag                            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu32
  import alu_control_pkg::*;
(
  input  logic [3:0]  i_aluc,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic [4:0] w_shamt;

  assign w_shamt = i_a[4:0];

  always_comb begin
    o_result = '0;
    case (i_aluc)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_LUI: o_result = {i_b[15:0], 16'h0000};
      ALU_SLL: o_result = i_b << w_shamt;
      ALU_SRL: o_result = i_b >> w_shamt;
      ALU_SRA: o_result = $unsigned($signed(i_b) >>> w_shamt);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == 32'h0);

endmodule

`default_nettype wire

// File: rtl/alu_control_dmem.sv
// +--------------------------------------------------------------------------+
// | alu_control_dmem : control decoder, ALU and word-addressed data memory.  |
// | Optional ALU_OVF_EN adds signed-overflow port ovf and write suppression. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_control_dmem
  import alu_control_pkg::*;
#(
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  input  logic [31:0] store_data,
  output logic        jump,
  output logic        m2reg,
  output logic        branch,
  output logic        wmem,
  output logic        shift,
  output logic        aluimm,
  output logic        wreg,
  output logic        sext,
  output logic        regrt,
  output logic [3:0]  aluc,
  output logic [31:0] alu_result,
  output logic        zero,
  output logic [31:0] mem_rdata
`ifdef ALU_OVF_EN
  ,
  output logic        ovf
`endif
);

  localparam int C_AW = $clog2(DMEM_WORDS);

  logic w_wreg;
  logic w_is_beq;
  logic w_is_bne;

  always_comb begin
    jump     = 1'b0;
    m2reg    = 1'b0;
    wmem     = 1'b0;
    shift    = 1'b0;
    aluimm   = 1'b0;
    w_wreg   = 1'b0;
    sext     = 1'b0;
    regrt    = 1'b0;
    aluc     = ALU_ADD;
    w_is_beq = 1'b0;
    w_is_bne = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD: begin w_wreg = 1'b1; aluc = ALU_ADD; end
          FN_SUB: begin w_wreg = 1'b1; aluc = ALU_SUB; end
          FN_AND: begin w_wreg = 1'b1; aluc = ALU_AND; end
          FN_OR:  begin w_wreg = 1'b1; aluc = ALU_OR;  end
          FN_XOR: begin w_wreg = 1'b1; aluc = ALU_XOR; end
          FN_SLL: begin w_wreg = 1'b1; shift = 1'b1; aluc = ALU_SLL; end
          FN_SRL: begin w_wreg = 1'b1; shift = 1'b1; aluc = ALU_SRL; end
          FN_SRA: begin w_wreg = 1'b1; shift = 1'b1; aluc = ALU_SRA; end
          FN_JR:  jump = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI: begin aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; sext = 1'b1; aluc = ALU_ADD; end
      OP_ANDI: begin aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; aluc = ALU_AND; end
      OP_ORI:  begin aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; aluc = ALU_OR;  end
      OP_XORI: begin aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; aluc = ALU_XOR; end
      OP_LUI:  begin aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; aluc = ALU_LUI; end
      OP_LW: begin
        aluimm = 1'b1; regrt = 1'b1; w_wreg = 1'b1; sext = 1'b1; m2reg = 1'b1;
      end
      OP_SW:  begin aluimm = 1'b1; regrt = 1'b1; sext = 1'b1; wmem = 1'b1; end
      OP_BEQ: begin sext = 1'b1; aluc = ALU_SUB; w_is_beq = 1'b1; end
      OP_BNE: begin sext = 1'b1; aluc = ALU_SUB; w_is_bne = 1'b1; end
      OP_J:   jump = 1'b1;
      OP_JAL: begin jump = 1'b1; w_wreg = 1'b1; end
      default: ;
    endcase
  end

  alu32 u_alu32 (
    .i_aluc   (aluc),
    .i_a      (alu_a),
    .i_b      (alu_b),
    .o_result (alu_result),
    .o_zero   (zero)
  );

  assign branch = (w_is_beq & zero) | (w_is_bne & ~zero);

`ifdef ALU_OVF_EN
  logic w_ovf_op;
  logic w_add_ovf;
  logic w_sub_ovf;

  // Only add/addi/sub trap; lw/sw/branches share the adder but never flag.
  assign w_ovf_op  = ((op == OP_RTYPE) && ((func == FN_ADD) || (func == FN_SUB))) ||
                     (op == OP_ADDI);
  assign w_add_ovf = (alu_a[31] == alu_b[31]) && (alu_result[31] != alu_a[31]);
  assign w_sub_ovf = (alu_a[31] != alu_b[31]) && (alu_result[31] != alu_a[31]);
  assign ovf       = w_ovf_op & ((aluc == ALU_SUB) ? w_sub_ovf : w_add_ovf);
  assign wreg      = w_wreg & ~ovf;
`else
  assign wreg      = w_wreg;
`endif

  logic [31:0]     r_mem [DMEM_WORDS];
  logic [C_AW-1:0] w_idx;
  logic            w_unused;

  // Byte offset and bits above the depth are dropped: addresses alias modulo depth.
  assign w_idx     = alu_result[C_AW+1:2];
  assign w_unused  = &{1'b0, alu_result[31:C_AW+2], alu_result[1:0]};
  assign mem_rdata = r_mem[w_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wmem) begin
      r_mem[w_idx] <= store_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_control_dmem.sv
// +--------------------------------------------------------------------------+
// | tb_alu_control_dmem : directed self-checking bench for alu_control_dmem  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_control_dmem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  op, func;
  logic [31:0] alu_a, alu_b, store_data;
  logic        jump, m2reg, branch, wmem, shift, aluimm, wreg, sext, regrt;
  logic [3:0]  aluc;
  logic [31:0] alu_result, mem_rdata;
  logic        zero;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_control_dmem #(.DMEM_WORDS(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .func       (func),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .store_data (store_data),
    .jump       (jump),
    .m2reg      (m2reg),
    .branch     (branch),
    .wmem       (wmem),
    .shift      (shift),
    .aluimm     (aluimm),
    .wreg       (wreg),
    .sext       (sext),
    .regrt      (regrt),
    .aluc       (aluc),
    .alu_result (alu_result),
    .zero       (zero),
    .mem_rdata  (mem_rdata)
`ifdef ALU_OVF_EN
    ,
    .ovf        (ovf)
`endif
  );

  always #5 clk = ~clk;

  // {jump,m2reg,branch,wmem,shift,aluimm,wreg,sext,regrt,aluc}
  function automatic logic [31:0] ctrl_now();
    return {19'd0, jump, m2reg, branch, wmem, shift, aluimm, wreg, sext, regrt, aluc};
  endfunction

  function automatic logic [31:0] cv(input logic j, m, b, w, s, ai, wr, se, rt,
                                     input logic [3:0] c);
    return {19'd0, j, m, b, w, s, ai, wr, se, rt, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] sd);
    op = o; func = f; alu_a = a; alu_b = b; store_data = sd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(6'b111111, 6'd0, 32'd0, 32'd0, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

    // Fill words 0..3, then confirm one landed
    for (int i = 0; i < 4; i++) begin
      drive(6'b101011, 6'd0, 32'(4 * i), 32'd0, 32'hA0 + 32'(i));
      tick();
    end
    drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd0);
    chk("pre_reset_word2", mem_rdata, 32'h000000A2);
    chk("lw_ctrl", ctrl_now(), cv(0, 1, 0, 0, 0, 1, 1, 1, 1, 4'b0000));

    // Reset with a concurrent sw: controls still decode, memory is cleared
    drive(6'b101011, 6'd0, 32'd0, 32'd0, 32'h55555555);
    rst_n = 1'b0;
    chk("sw_ctrl_in_reset", ctrl_now(), cv(0, 0, 0, 1, 0, 1, 0, 1, 1, 4'b0000));
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(6'b100011, 6'd0, 32'(4 * i), 32'd0, 32'd0);
      chk($sformatf("reset_word%0d", i), mem_rdata, 32'd0);
    end

    // add
    drive(6'b000000, 6'b100000, 32'd7, 32'd5, 32'd0);
    chk("add_ctrl", ctrl_now(), cv(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
    chk("add_res", alu_result, 32'd12);
    chk("add_zero", {31'd0, zero}, 32'd0);
    drive(6'b000000, 6'b100000, 32'hFFFFFFFF, 32'd1, 32'd0);
    chk("add_wrap_res", alu_result, 32'd0);
    chk("add_wrap_zero", {31'd0, zero}, 32'd1);

    // sub / logic ops
    drive(6'b000000, 6'b100010, 32'd5, 32'd7, 32'd0);
    chk("sub_ctrl", ctrl_now(), cv(0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0100));
    chk("sub_res", alu_result, 32'hFFFFFFFE);
    drive(6'b000000, 6'b100100, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
    chk("and_res", alu_result, 32'hF000F000);
    drive(6'b000000, 6'b100101, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
    chk("or_res", alu_result, 32'hFFF0FFF0);
    drive(6'b000000, 6'b100110, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
    chk("xor_res", alu_result, 32'h0FF00FF0);
    drive(6'b001110, 6'd0, 32'h0000FFFF, 32'h00000F0F, 32'd0);
    chk("xori_ctrl", ctrl_now(), cv(0, 0, 0, 0, 0, 1, 1, 0, 1, 4'b0010));
    chk("xori_res", alu_result, 32'h0000F0F0);

    // shifts and lui
    drive(6'b000000, 6'b000011, 32'd4, 32'h80000000, 32'd0);
    chk("sra_ctrl", ctrl_now(), cv(0, 0, 0, 0, 1, 0, 1, 0, 0, 4'b1111));
    chk("sra_res", alu_result, 32'hF8000000);
    drive(6'b000000, 6'b000010, 32'd4, 32'h80000000, 32'd0);
    chk("srl_res", alu_result, 32'h08000000);
    drive(6'b000000, 6'b000000, 32'h00000024, 32'd1, 32'd0);
    chk("sll_shamt5_res", alu_result, 32'h00000010);
    drive(6'b001111, 6'd0, 32'd0, 32'h00001234, 32'd0);
    chk("lui_ctrl", ctrl_now(), cv(0, 0, 0, 0, 0, 1, 1, 0, 1, 4'b0110));
    chk("lui_res", alu_result, 32'h12340000);

    // memory store/load and aliasing
    drive(6'b101011, 6'd0, 32'd8, 32'd0, 32'hDEADBEEF);
    tick();
    drive(6'b100011, 6'd0, 32'd8, 32'd0, 32'd0);
    chk("lw_m2reg", {31'd0, m2reg}, 32'd1);
    chk("lw_data", mem_rdata, 32'hDEADBEEF);
    drive(6'b100011, 6'd0, 32'd0, 32'd139, 32'd0);
    chk("lw_alias_data", mem_rdata, 32'hDEADBEEF);
    drive(6'b101011, 6'd0, 32'd136, 32'd0, 32'hCAFEF00D);
    chk("rdw_old", mem_rdata, 32'hDEADBEEF);
    tick();
    chk("rdw_new", mem_rdata, 32'hCAFEF00D);
    drive(6'b100011, 6'd0, 32'd12, 32'd0, 32'd0);
    chk("neighbour_word3", mem_rdata, 32'd0);

    // branches, jumps, undefined encodings
    drive(6'b000100, 6'd0, 32'd3, 32'd3, 32'd0);
    chk("beq_taken_ctrl", ctrl_now(), cv(0, 0, 1, 0, 0, 0, 0, 1, 0, 4'b0100));
    drive(6'b000101, 6'd0, 32'd3, 32'd3, 32'd0);
    chk("bne_not_taken", {31'd0, branch}, 32'd0);
    drive(6'b000101, 6'd0, 32'd3, 32'd4, 32'd0);
    chk("bne_taken", {31'd0, branch}, 32'd1);
    drive(6'b000011, 6'd0, 32'd0, 32'd0, 32'd0);
    chk("jal_ctrl", ctrl_now(), cv(1, 0, 0, 0, 0, 0, 1, 0, 0, 4'b0000));
    drive(6'b000000, 6'b001000, 32'd0, 32'd0, 32'd0);
    chk("jr_ctrl", ctrl_now(), cv(1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000));
    drive(6'b111111, 6'd0, 32'd9, 32'd9, 32'd0);
    chk("undef_op_ctrl", ctrl_now(), 32'd0);
    drive(6'b000000, 6'b111111, 32'd9, 32'd9, 32'd0);
    chk("undef_func_ctrl", ctrl_now(), 32'd0);

`ifdef ALU_OVF_EN
    drive(6'b000000, 6'b100000, 32'h7FFFFFFF, 32'd1, 32'd0);
    chk("add_ovf", {31'd0, ovf}, 32'd1);
    chk("add_ovf_wreg", {31'd0, wreg}, 32'd0);
    drive(6'b000000, 6'b100010, 32'h80000000, 32'd1, 32'd0);
    chk("sub_ovf", {31'd0, ovf}, 32'd1);
    drive(6'b100011, 6'd0, 32'h7FFFFFFF, 32'd1, 32'd0);
    chk("lw_no_ovf", {31'd0, ovf}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
